// File: rtl/loader_pkg.sv
// Shared types and constants for bram_debug_loader.
// Defining LOADER_ZERO_FILL_EN adds the ST_ZFILL state.
package loader_pkg;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_DUMP = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef LOADER_ZERO_FILL_EN
        ST_ZFILL,
`endif
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_HOLD
    } state_e;

    localparam logic [3:0] WE_ALL     = 4'b1111;
    localparam int         WORD_BYTES = 4;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/loader_chan_demux.sv
// Routes the single debug port of the active channel onto the flattened
// per-channel buses; every other channel sees zeros.
module loader_chan_demux
    import loader_pkg::*;
#(
    parameter  int CHANNELS = 2,
    localparam int CW       = chan_bits(CHANNELS)
) (
    input  logic [CW-1:0]            i_chan,
    input  logic [31:0]              i_a,
    input  logic [31:0]              i_wd,
    input  logic [3:0]               i_we,
    input  logic [32*CHANNELS-1:0]   i_dbg_rd,
    output logic [31:0]              o_rd,
    output logic [32*CHANNELS-1:0]   o_dbg_a,
    output logic [32*CHANNELS-1:0]   o_dbg_wd,
    output logic [4*CHANNELS-1:0]    o_dbg_we
);

    always_comb begin
        o_rd     = '0;
        o_dbg_a  = '0;
        o_dbg_wd = '0;
        o_dbg_we = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(i_chan) == c) begin
                o_dbg_a[32*c +: 32]  = i_a;
                o_dbg_wd[32*c +: 32] = i_wd;
                o_dbg_we[4*c +: 4]   = i_we;
                o_rd                 = i_dbg_rd[32*c +: 32];
            end
        end
    end

endmodule

// File: rtl/bram_debug_loader.sv
// Command/stream driven loader and dumper for BRAM debug ports.
// LOADER_ZERO_FILL_EN: zero-fill the rest of a load cut short by ld_last.
module bram_debug_loader
    import loader_pkg::*;
#(
    parameter  int WORDS      = 4096,
    parameter  int CHANNELS   = 2,
    parameter  int RST_CYCLES = 5,
    localparam int CW         = chan_bits(CHANNELS),
    localparam int IW         = $clog2(WORDS) + 1
) (
    input  logic                      CPU_CLK,
    input  logic                      CPU_RST,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_op,
    input  logic [CW-1:0]             cmd_chan,
    input  logic [IW-1:0]             cmd_count,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [31:0]               ld_data,
    input  logic                      ld_last,
    output logic                      dp_valid,
    input  logic                      dp_ready,
    output logic [31:0]               dp_data,
    output logic [31:0]               dp_addr,
    output logic [32*CHANNELS-1:0]    dbg_a,
    output logic [32*CHANNELS-1:0]    dbg_wd,
    output logic [4*CHANNELS-1:0]     dbg_we,
    input  logic [32*CHANNELS-1:0]    dbg_rd,
    output logic                      core_rst_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int            HOLD_N    = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int            HW        = $clog2(HOLD_N + 1);
    localparam logic [IW-1:0] WORDS_V   = IW'(WORDS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_N - 1);

    state_e          r_state;
    state_e          w_next;
    logic [CW-1:0]   r_chan;
    logic [IW-1:0]   r_count;
    logic [IW-1:0]   r_idx;
    logic [HW-1:0]   r_hold;
    logic            r_err;
    logic            r_never;
    logic            r_up;
    logic [31:0]     r_a;
    logic [31:0]     r_wd;
    logic [3:0]      r_we;
    logic            r_dpv;
    logic [31:0]     r_dpd;
    logic [31:0]     r_dpa;

    logic            w_accept;
    logic            w_chan_ok;
    logic            w_last_idx;
    logic            w_wr;
    logic            w_zero;
    logic            w_step;
    logic [IW-1:0]   w_idx_inc;
    logic [IW-1:0]   w_count;
    logic [31:0]     w_rd;

    function automatic logic [31:0] f_addr(input logic [IW-2:0] idx);
        return 32'(idx) * 32'(WORD_BYTES);
    endfunction

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_chan_ok  = int'(cmd_chan) < CHANNELS;
    assign w_idx_inc  = r_idx + 1'b1;
    assign w_last_idx = w_idx_inc == r_count;
    assign w_count    = (cmd_count == '0 || cmd_count > WORDS_V)
                      ? WORDS_V : cmd_count;

    always_comb begin
        w_next = r_state;
        w_wr   = 1'b0;
        w_zero = 1'b0;
        w_step = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_chan_ok)
                        w_next = ST_HOLD;
                    else if (op_e'(cmd_op) == OP_DUMP)
                        w_next = ST_RD_ISSUE;
                    else
                        w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    w_wr   = 1'b1;
                    w_step = 1'b1;
                    if (w_last_idx) begin
                        w_next = ST_HOLD;
                    end else if (ld_last) begin
`ifdef LOADER_ZERO_FILL_EN
                        w_next = ST_ZFILL;
`else
                        w_next = ST_HOLD;
`endif
                    end
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            ST_ZFILL: begin
                w_wr   = 1'b1;
                w_zero = 1'b1;
                w_step = 1'b1;
                if (w_last_idx)
                    w_next = ST_HOLD;
            end
`endif
            ST_RD_ISSUE: w_next = ST_RD_WAIT;
            ST_RD_WAIT:  w_next = ST_RD_OUT;
            ST_RD_OUT: begin
                if (r_dpv && dp_ready) begin
                    w_step = 1'b1;
                    w_next = w_last_idx ? ST_HOLD : ST_RD_ISSUE;
                end
            end
            ST_HOLD: begin
                if (r_hold == HOLD_LAST)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            r_up    <= 1'b0;
            r_never <= 1'b1;
            r_chan  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_hold  <= '0;
            r_a     <= '0;
            r_wd    <= '0;
            r_we    <= '0;
            r_dpv   <= 1'b0;
            r_dpd   <= '0;
            r_dpa   <= '0;
        end else begin
            r_up <= 1'b1;
            r_a  <= '0;
            r_wd <= '0;
            r_we <= '0;
            if (w_accept) begin
                r_chan  <= cmd_chan;
                r_count <= w_count;
                r_idx   <= '0;
                r_err   <= !w_chan_ok;
            end else if (w_step) begin
                r_idx <= w_idx_inc;
            end
            // Debug port strobes last exactly one cycle, then return to zero.
            if (w_wr) begin
                r_a  <= f_addr(r_idx[IW-2:0]);
                r_wd <= w_zero ? '0 : ld_data;
                r_we <= WE_ALL;
            end else if (w_next == ST_RD_ISSUE) begin
                r_a <= w_accept ? '0 : f_addr(w_idx_inc[IW-2:0]);
            end
            if (r_state == ST_RD_WAIT) begin
                r_dpv <= 1'b1;
                r_dpd <= w_rd;
                r_dpa <= f_addr(r_idx[IW-2:0]);
            end else if (r_state == ST_RD_OUT && w_step) begin
                r_dpv <= 1'b0;
            end
            r_hold <= (r_state == ST_HOLD) ? r_hold + 1'b1 : '0;
            if (r_state == ST_HOLD && w_next == ST_IDLE)
                r_never <= 1'b0;
        end
    end

    loader_chan_demux #(
        .CHANNELS (CHANNELS)
    ) u_demux (
        .i_chan   (r_chan),
        .i_a      (r_a),
        .i_wd     (r_wd),
        .i_we     (r_we),
        .i_dbg_rd (dbg_rd),
        .o_rd     (w_rd),
        .o_dbg_a  (dbg_a),
        .o_dbg_wd (dbg_wd),
        .o_dbg_we (dbg_we)
    );

    assign cmd_ready     = r_up && (r_state == ST_IDLE);
    assign ld_ready      = r_state == ST_LOAD;
    assign dp_valid      = r_dpv;
    assign dp_data       = r_dpd;
    assign dp_addr       = r_dpa;
    assign busy          = r_state != ST_IDLE;
    assign core_rst_hold = busy || r_never;
    assign done          = (r_state == ST_HOLD) && (r_hold == '0);
    assign err           = done && r_err;

endmodule

// File: tb/tb_bram_debug_loader.sv
// Directed bench for bram_debug_loader with a behavioural BRAM per channel.
// Expectations for the short-load case follow LOADER_ZERO_FILL_EN.
module tb_bram_debug_loader;
    import loader_pkg::*;

    localparam int WORDS      = 64;
    localparam int CHANNELS   = 3;
    localparam int RST_CYCLES = 5;
    localparam int CW         = 2;
    localparam int IW         = $clog2(WORDS) + 1;
    localparam int AW         = $clog2(WORDS);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmd_valid, cmd_ready, cmd_op;
    logic [CW-1:0]           cmd_chan;
    logic [IW-1:0]           cmd_count;
    logic                    ld_valid, ld_ready, ld_last;
    logic [31:0]             ld_data;
    logic                    dp_valid, dp_ready;
    logic [31:0]             dp_data, dp_addr;
    logic [32*CHANNELS-1:0]  dbg_a, dbg_wd, dbg_rd;
    logic [4*CHANNELS-1:0]   dbg_we;
    logic                    core_rst_hold, busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;
    int bad_addr = 0;

    int          wr_ch[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [3:0]  wr_we[$];
    logic [31:0] exp_d[$];

    logic [31:0] mem  [CHANNELS][WORDS];
    bit          wbit [CHANNELS][WORDS];

    always #5 clk = ~clk;

    bram_debug_loader #(
        .WORDS      (WORDS),
        .CHANNELS   (CHANNELS),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .CPU_CLK       (clk),
        .CPU_RST       (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_chan      (cmd_chan),
        .cmd_count     (cmd_count),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .ld_last       (ld_last),
        .dp_valid      (dp_valid),
        .dp_ready      (dp_ready),
        .dp_data       (dp_data),
        .dp_addr       (dp_addr),
        .dbg_a         (dbg_a),
        .dbg_wd        (dbg_wd),
        .dbg_we        (dbg_we),
        .dbg_rd        (dbg_rd),
        .core_rst_hold (core_rst_hold),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Channel 1 starts with a known pattern so untouched words are visible.
    function automatic logic [31:0] mem_val(input int c, input int i);
        if (wbit[c][i]) return mem[c][i];
        return (c == 1) ? 32'h1000 + 32'(i) : 32'h0;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (dbg_a[32*c +: 32] > 32'((WORDS - 1) * 4)) bad_addr++;
            if (dbg_we[4*c +: 4] != 4'b0) begin
                wr_ch.push_back(c);
                wr_a.push_back(dbg_a[32*c +: 32]);
                wr_d.push_back(dbg_wd[32*c +: 32]);
                wr_we.push_back(dbg_we[4*c +: 4]);
                mem[c][dbg_a[32*c+2 +: AW]]  <= dbg_wd[32*c +: 32];
                wbit[c][dbg_a[32*c+2 +: AW]] <= 1'b1;
            end
            dbg_rd[32*c +: 32] <= mem_val(c, int'(dbg_a[32*c+2 +: AW]));
        end
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_ch.delete();
        wr_a.delete();
        wr_d.delete();
        wr_we.delete();
    endtask

    task automatic send_cmd(input logic op, input logic [CW-1:0] ch,
                            input logic [IW-1:0] cnt);
        int k;
        k = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_chan  = ch;
        cmd_count = cnt;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_load(input int n, input int last_at,
                             input logic [31:0] d0, input logic [31:0] step);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            ld_valid = 1'b1;
            ld_data  = d0 + step * 32'(i);
            ld_last  = (i == last_at);
            while (!ld_ready && k < 100) begin
                tick();
                k++;
            end
            if (!ld_ready) begin
                check("ld_ready_timeout", 32'(ld_ready), 32'd1);
                break;
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic recv_dump(input string tag, input int n, input bit toggle);
        int          got;
        int          k;
        bit          stalled;
        logic [31:0] sd, sa;
        got = 0;
        k = 0;
        stalled = 1'b0;
        sd = '0;
        sa = '0;
        dp_ready = 1'b0;
        while (got < n && k < 300) begin
            dp_ready = toggle ? ~dp_ready : 1'b1;
            if (dp_valid) begin
                if (stalled) begin
                    check($sformatf("%s_stable_d%0d", tag, got), dp_data, sd);
                    check($sformatf("%s_stable_a%0d", tag, got), dp_addr, sa);
                end
                if (dp_ready) begin
                    check($sformatf("%s_a%0d", tag, got), dp_addr, 32'(got * 4));
                    check($sformatf("%s_d%0d", tag, got), dp_data, exp_d[got]);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sd = dp_data;
                    sa = dp_addr;
                end
            end
            tick();
            k++;
        end
        dp_ready = 1'b0;
        check({tag, "_words"}, 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] e;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_chan  = '0;
        cmd_count = '0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        ld_data   = '0;
        dp_ready  = 1'b0;

        // Reset values
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_dp_valid", 32'(dp_valid), 32'd0);
        check("rst_dp_data", dp_data, 32'd0);
        check("rst_dp_addr", dp_addr, 32'd0);
        check("rst_dbg_we", 32'(dbg_we), 32'd0);
        check("rst_dbg_a", dbg_a[31:0] | dbg_a[63:32] | dbg_a[95:64], 32'd0);
        check("rst_done_err", {30'b0, done, err}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hold", 32'(core_rst_hold), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        check("hold_before_first", 32'(core_rst_hold), 32'd1);

        // LOAD ch0, 4 words
        clear_log();
        send_cmd(OP_LOAD, 2'd0, 7'd4);
        send_load(4, -1, 32'h11, 32'h11);
        check("ld1_done", 32'(done), 32'd1);
        check("ld1_err", 32'(err), 32'd0);
        n = 0;
        while (core_rst_hold && n < 20) begin
            tick();
            n++;
        end
        check("ld1_hold_fall", 32'(n), 32'(RST_CYCLES));
        check("ld1_nwr", 32'(wr_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            check($sformatf("ld1_ch%0d", i), 32'(wr_ch[i]), 32'd0);
            check($sformatf("ld1_a%0d", i), wr_a[i], 32'(i * 4));
            check($sformatf("ld1_d%0d", i), wr_d[i], 32'h11 * 32'(i + 1));
            check($sformatf("ld1_we%0d", i), 32'(wr_we[i]), 32'hF);
        end

        // LOAD ch1 count 8, ld_last on the third word
        clear_log();
        send_cmd(OP_LOAD, 2'd1, 7'd8);
        send_load(3, 2, 32'hA1, 32'h1);
        wait_idle();
`ifdef LOADER_ZERO_FILL_EN
        check("ld2_nwr", 32'(wr_a.size()), 32'd8);
        if (wr_a.size() > 0) check("ld2_last_a", wr_a[wr_a.size()-1], 32'h1C);
`else
        check("ld2_nwr", 32'(wr_a.size()), 32'd3);
        if (wr_a.size() > 0) check("ld2_last_a", wr_a[wr_a.size()-1], 32'h8);
`endif
        for (int i = 0; i < 8; i++) begin
`ifdef LOADER_ZERO_FILL_EN
            e = (i < 3) ? 32'hA1 + 32'(i) : 32'h0;
`else
            e = (i < 3) ? 32'hA1 + 32'(i) : 32'h1000 + 32'(i);
`endif
            check($sformatf("ld2_mem%0d", i), mem_val(1, i), e);
        end

        // DUMP ch0 count 4 with dp_ready toggling
        exp_d.delete();
        for (int i = 0; i < 4; i++) exp_d.push_back(32'h11 * 32'(i + 1));
        send_cmd(OP_DUMP, 2'd0, 7'd4);
        recv_dump("dp1", 4, 1'b1);
        check("dp1_done", 32'(done), 32'd1);
        check("dp1_err", 32'(err), 32'd0);
        wait_idle();

        // DUMP ch1 count 1: latency from accept
        send_cmd(OP_DUMP, 2'd1, 7'd1);
        check("dp2_lat_issue", 32'(dp_valid), 32'd0);
        tick();
        check("dp2_lat_wait", 32'(dp_valid), 32'd0);
        tick();
        check("dp2_lat_out", 32'(dp_valid), 32'd1);
        check("dp2_data", dp_data, 32'hA1);
        check("dp2_addr", dp_addr, 32'h0);
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        check("dp2_done", 32'(done), 32'd1);
        check("dp2_valid_drop", 32'(dp_valid), 32'd0);
        wait_idle();

        // LOAD count 0 means WORDS words
        clear_log();
        send_cmd(OP_LOAD, 2'd2, 7'd0);
        send_load(WORDS, -1, 32'h500, 32'h1);
        check("ld0_done", 32'(done), 32'd1);
        check("ld0_ld_ready", 32'(ld_ready), 32'd0);
        wait_idle();
        check("ld0_nwr", 32'(wr_a.size()), 32'(WORDS));
        if (wr_a.size() > 0) begin
            check("ld0_first_a", wr_a[0], 32'h0);
            check("ld0_last_a", wr_a[wr_a.size()-1], 32'((WORDS - 1) * 4));
            check("ld0_last_d", wr_d[wr_d.size()-1], 32'h500 + 32'(WORDS - 1));
        end

        // LOAD count above WORDS clamps to WORDS
        clear_log();
        send_cmd(OP_LOAD, 2'd2, 7'd100);
        send_load(WORDS, -1, 32'h700, 32'h1);
        check("ldbig_done", 32'(done), 32'd1);
        wait_idle();
        check("ldbig_nwr", 32'(wr_a.size()), 32'(WORDS));

        // Out-of-range channel
        clear_log();
        send_cmd(OP_LOAD, 2'd3, 7'd4);
        check("bad_done", 32'(done), 32'd1);
        check("bad_err", 32'(err), 32'd1);
        check("bad_ld_ready", 32'(ld_ready), 32'd0);
        wait_idle();
        check("bad_nwr", 32'(wr_a.size()), 32'd0);

        // Reset in the middle of a dump
        send_cmd(OP_DUMP, 2'd0, 7'd4);
        n = 0;
        while (!dp_valid && n < 10) begin
            tick();
            n++;
        end
        check("mid_valid_seen", 32'(dp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_dp_valid", 32'(dp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_hold", 32'(core_rst_hold), 32'd1);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        exp_d.delete();
        for (int i = 0; i < 3; i++) exp_d.push_back(32'hA1 + 32'(i));
        send_cmd(OP_DUMP, 2'd1, 7'd3);
        recv_dump("dp3", 3, 1'b0);
        check("dp3_done", 32'(done), 32'd1);
        wait_idle();
        check("dp3_hold_rel", 32'(core_rst_hold), 32'd0);

        check("addr_bound", 32'(bad_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
